// File: rtl/rf_write_sched_pkg.sv
// Shared widths and requester indices for the register-file write-port scheduler.
package rf_pkg;
  localparam int DATA_W  = 32;
  localparam int REG_W   = 4;
  localparam int NREGS   = 1 << REG_W;
  localparam int REQ_ALU = 0;
  localparam int REQ_LD  = 1;

  typedef logic [REG_W-1:0]  reg_idx_t;
  typedef logic [DATA_W-1:0] data_t;
endpackage

// File: rtl/rf_write_sched_if.sv
// Writeback requests, destination reservation and DPRF write pins, bundled for the scheduler.
interface rf_write_sched_if;
  import rf_pkg::*;

  logic             req0_valid;
  logic             req0_ready;
  reg_idx_t         req0_dest;
  data_t            req0_data;
  logic             req1_valid;
  logic             req1_ready;
  reg_idx_t         req1_dest;
  data_t            req1_data;
  logic             alloc_valid;
  reg_idx_t         alloc_reg;
  logic             alloc_ready;
  logic [NREGS-1:0] busy;
  logic             we;
  reg_idx_t         regsel_dest;
  data_t            datain;

  modport master (
    output req0_valid, req0_dest, req0_data,
    output req1_valid, req1_dest, req1_data,
    output alloc_valid, alloc_reg,
    input  req0_ready, req1_ready, alloc_ready,
    input  busy, we, regsel_dest, datain
  );

  modport slave (
    input  req0_valid, req0_dest, req0_data,
    input  req1_valid, req1_dest, req1_data,
    input  alloc_valid, alloc_reg,
    output req0_ready, req1_ready, alloc_ready,
    output busy, we, regsel_dest, datain
  );
endinterface

// File: rtl/rf_write_sched_rr_arb2.sv
// Two-way round-robin arbiter; on contention the requester that did not win last time is granted.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid_i,
  input  logic       xfer_i,
  output logic [1:0] grant_o
);
  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    grant_o = valid_i;
    if (valid_i == 2'b11) begin
      grant_o = last_grant_q ? 2'b01 : 2'b10;
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (xfer_i) begin
      last_grant_d = grant_o[1];
    end
  end

  // Reset to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
endmodule

// File: rtl/rf_write_sched.sv
// DPRF write-port scheduler: arbitrates two writeback sources, registers the winner onto the
// write pins and tracks per-register pending writes in a busy scoreboard.
module rf_write_sched
  import rf_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  rf_write_sched_if.slave   bus
);
  logic [1:0]       grant;
  logic             xfer;
  logic             alloc_ok;
  reg_idx_t         win_dest;
  data_t            win_data;

  logic             we_q,    we_d;
  reg_idx_t         sel_q,   sel_d;
  data_t            data_q,  data_d;
  logic [NREGS-1:0] busy_q,  busy_d;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .valid_i ({bus.req1_valid, bus.req0_valid}),
    .xfer_i  (xfer),
    .grant_o (grant)
  );

  // Handshakes are suppressed while reset is held.
  assign bus.req0_ready  = grant[REQ_ALU] & ~reset;
  assign bus.req1_ready  = grant[REQ_LD]  & ~reset;
  assign bus.alloc_ready = ~busy_q[bus.alloc_reg] & ~reset;

  assign xfer     = bus.req0_ready | bus.req1_ready;
  assign alloc_ok = bus.alloc_valid & bus.alloc_ready;
  assign win_dest = bus.req1_ready ? bus.req1_dest : bus.req0_dest;
  assign win_data = bus.req1_ready ? bus.req1_data : bus.req0_data;

  always_comb begin
    we_d   = xfer;
    sel_d  = sel_q;
    data_d = data_q;
    if (xfer) begin
      sel_d  = win_dest;
      data_d = win_data;
    end
  end

  // The clear lands on the same edge the DPRF captures, so released readers see new data.
  always_comb begin
    busy_d = busy_q;
    if (we_q) begin
      busy_d[sel_q] = 1'b0;
    end
    if (alloc_ok) begin
      busy_d[bus.alloc_reg] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q   <= 1'b0;
      sel_q  <= '0;
      data_q <= '0;
      busy_q <= '0;
    end else begin
      we_q   <= we_d;
      sel_q  <= sel_d;
      data_q <= data_d;
      busy_q <= busy_d;
    end
  end

  assign bus.we          = we_q;
  assign bus.regsel_dest = sel_q;
  assign bus.datain      = data_q;
  assign bus.busy        = busy_q;
endmodule

// File: doc/rf_write_sched.md
# rf_write_sched

Write-port scheduler and scoreboard for the 16 x 32 dual-port register file (DPRF). It arbitrates between two writeback requesters (ALU and load unit) for the DPRF's single write port using round-robin priority. It registers the winning write onto the DPRF `we`/`regsel_dest`/`datain` pins. It also keeps a per-register busy scoreboard that issue logic uses to stall reads of registers with writes still in flight.

## Interface
- `DATA_W`, 32, register data width
- `REG_W`, 4, register select width (2^REG_W = 16 registers)

- `clk`  in  1  system clock, rising edge
- `reset`  in  1  synchronous, active-high
- `req0_valid`  in  1  requester 0 (ALU) has a write
- `req0_ready`  out  1  requester 0 write accepted this cycle
- `req0_dest`  in  REG_W  requester 0 destination register
- `req0_data`  in  DATA_W  requester 0 write data
- `req1_valid`, `req1_ready`, `req1_dest`, `req1_data`: same for requester 1 (load unit)
- `alloc_valid`  in  1  issue logic reserves a destination
- `alloc_reg`  in  REG_W  register to reserve
- `alloc_ready`  out  1  reservation accepted this cycle
- `busy`  out  2^REG_W  scoreboard, bit i = register i has a write pending
- `we`  out  1  DPRF write enable
- `regsel_dest`  out  REG_W  DPRF write register select
- `datain`  out  DATA_W  DPRF write data

## Operation
- Handshake: a transfer occurs on a rising edge where valid && ready. Requesters hold valid/dest/data stable until ready.
- Arbitration is combinational from the inputs and the `last_grant` register.
  - Only one valid: that requester gets ready=1.
  - Both valid: grant the requester that is not `last_grant`. The loser's ready=0.
  - `last_grant` updates to the granted index on every transfer.
- The output stage accepts one write every cycle, with no back-pressure from the DPRF.
  - On a transfer, `we`, `regsel_dest` and `datain` load the granted request at that edge.
  - With no transfer, `we` goes to 0. `regsel_dest` and `datain` hold their last value.
- Scoreboard, `busy` register:
  - `alloc_ready = !busy[alloc_reg]`.
  - An accepted alloc sets `busy[alloc_reg]` at the edge.
  - When `we`=1, `busy[regsel_dest]` clears at that same edge, which is also the edge the DPRF writes.
  - A write to a register that is not busy still commits to the DPRF; the busy clear is then a no-op.
  - Commit and alloc in the same cycle on the same register: alloc_ready was 0 because busy=1, so the register ends up clear. Commit and alloc on different registers: both take effect.
- No register is hard-wired zero. All 16 registers are writable.

## Timing
- Reset values: `we`=0, `regsel_dest`=0, `datain`=0, `busy`=0, `last_grant`=1 (requester 0 wins the first contention).
- `req*_ready` and `alloc_ready` are combinational, with zero latency.
- Write latency: transfer at edge E0, `we`=1 during cycle E0..E1, DPRF captures at E1, `busy` bit reads 0 from E1 onward.
  - A reader released by `busy`=0 therefore sees the new DPRF data, so no forwarding is needed.
- Throughput is 1 write per cycle. With both requesters continuously valid, grants alternate 0,1,0,1.
- Reset asserted mid-operation:
  - An in-flight output-stage write is dropped: `we`=0 next cycle.
  - The scoreboard clears.
  - ready outputs are forced to 0 while reset=1.

## Structure
- Package `rf_pkg`: `DATA_W`, `REG_W`, `NREGS`, and the requester index constants `REQ_ALU`=0 and `REQ_LD`=1.
- Sub-module `rr_arb2`: 2-way round-robin arbiter owning `last_grant`. It takes valid[1:0] and a transfer strobe, and outputs grant[1:0].
- The top level holds the output stage and scoreboard, and connects directly to the DPRF write pins.

## Test plan
- Single write: alloc r3, then req0 dest=3 data=30 → `busy[3]`=1. Next edge `we`=1, `regsel_dest`=3, `datain`=30. One edge later `busy[3]`=0 and a DPRF read of r3 returns 30.
- Contention: both valid every cycle (req0 dest=10 data=100, req1 dest=5 data=7) → first grant to req0, then alternating. `we` stays high every cycle and the loser's ready is 0.
- Alloc blocked: `busy[10]`=1, alloc r10 → `alloc_ready`=0. After the r10 commit, `alloc_ready`=1 on the next cycle.
- Same-cycle commit plus alloc on different registers: commit r3 while allocating r4 → `busy[3]`=0 and `busy[4]`=1 after the edge.
- Reset mid-write: assert reset on the cycle `we`=1 → after the edge `we`=0, `busy`=0, both readies 0. After reset, the first contention is granted to req0.
- Idle: no valids → `we`=0, and `regsel_dest`/`datain` hold their previous values.
